// File: rtl/ps2_letter_rx.sv
// PS/2 keyboard receiver: conditions the raw clock/data pins, frames
// 11-bit PS/2 words, and maps scan-code set 2 make codes for A-Z to 1-26.
// Break (F0) and extended (E0) prefixes swallow the byte that follows them.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | waiting for a start bit (data 0 on a filtered falling edge)
// S_DATA   | shifting in the 8 data bits, LSB first
// S_PARITY | capturing the odd-parity bit
// S_STOP   | stop bit; frame is evaluated on its falling edge
module ps2_letter_rx #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 100_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       kbdclk,
  input  logic       kbddat,
  output logic [4:0] letter,
  output logic       letter_valid,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int FLT_W = $clog2(FILTER + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t     state_q, state_d;
  logic       kc_meta_q, kc_meta_d, kc_sync_q, kc_sync_d;
  logic       kd_meta_q, kd_meta_d, kd_sync_q, kd_sync_d;
  logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;
  logic       flt_q, flt_d;
  logic       flt_dly_q, flt_dly_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic       brk_q, brk_d;
  logic       ext_q, ext_d;
  logic [4:0] letter_q, letter_d;
  logic       lv_q, lv_d;
  logic       pe_q, pe_d;
  logic       fe_q, fe_d;
  logic       fall;
  logic       timeout_hit;
  logic [4:0] hit_code;

  // Scan-code set 2 make code to letter index; 0 means not a letter.
  function automatic logic [4:0] lookup(input logic [7:0] code);
    logic [4:0] idx;
    idx = 5'd0;
    case (code)
      8'h1C: idx = 5'd1;   8'h32: idx = 5'd2;   8'h21: idx = 5'd3;
      8'h23: idx = 5'd4;   8'h24: idx = 5'd5;   8'h2B: idx = 5'd6;
      8'h34: idx = 5'd7;   8'h33: idx = 5'd8;   8'h43: idx = 5'd9;
      8'h3B: idx = 5'd10;  8'h42: idx = 5'd11;  8'h4B: idx = 5'd12;
      8'h3A: idx = 5'd13;  8'h31: idx = 5'd14;  8'h44: idx = 5'd15;
      8'h4D: idx = 5'd16;  8'h15: idx = 5'd17;  8'h2D: idx = 5'd18;
      8'h1B: idx = 5'd19;  8'h2C: idx = 5'd20;  8'h3C: idx = 5'd21;
      8'h2A: idx = 5'd22;  8'h1D: idx = 5'd23;  8'h22: idx = 5'd24;
      8'h35: idx = 5'd25;  8'h1A: idx = 5'd26;
      default: idx = 5'd0;
    endcase
    return idx;
  endfunction

  assign fall     = flt_dly_q & ~flt_q;
  assign hit_code = lookup(shift_q);

  // Synchronizers, glitch filter on the PS/2 clock, and its edge register.
  always_comb begin
    kc_meta_d = kbdclk;
    kc_sync_d = kc_meta_q;
    kd_meta_d = kbddat;
    kd_sync_d = kd_meta_q;
    flt_d     = flt_q;
    flt_cnt_d = '0;
    flt_dly_d = flt_q;
    if (kc_sync_q != flt_q) begin
      if (flt_cnt_q == FLT_W'(FILTER - 1)) begin
        flt_d = kc_sync_q;
      end else begin
        flt_cnt_d = flt_cnt_q + 1'b1;
      end
    end
  end

  // Frame FSM, stall timer (down-counter reloaded on every edge) and byte layer.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    brk_d     = brk_q;
    ext_d     = ext_q;
    letter_d  = letter_q;
    lv_d      = 1'b0;
    pe_d      = 1'b0;
    fe_d      = 1'b0;

    timeout_hit = (state_q != S_IDLE) && !fall && (to_cnt_q == '0);
    if ((state_q == S_IDLE) || fall) begin
      to_cnt_d = TO_W'(TIMEOUT - 1);
    end else if (to_cnt_q != '0) begin
      to_cnt_d = to_cnt_q - 1'b1;
    end else begin
      to_cnt_d = to_cnt_q;
    end

    case (state_q)
      S_IDLE: begin
        if (fall && !kd_sync_q) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (fall) begin
          shift_d   = {kd_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (fall) begin
          par_d   = kd_sync_q;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (fall) begin
          state_d = S_IDLE;
          if (!kd_sync_q) begin
            fe_d = 1'b1;
          end else if ((^{shift_q, par_q}) != 1'b1) begin
            pe_d = 1'b1;
          end else if (shift_q == 8'hE0) begin
            ext_d = 1'b1;
          end else if (shift_q == 8'hF0) begin
            brk_d = 1'b1;
          end else if (brk_q || ext_q) begin
            brk_d = 1'b0;
            ext_d = 1'b0;
          end else if (hit_code != 5'd0) begin
            letter_d = hit_code;
            lv_d     = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (timeout_hit) begin
      state_d   = S_IDLE;
      bit_cnt_d = '0;
      shift_d   = '0;
      fe_d      = 1'b1;
    end
  end

  // State register; idle-high line levels are the reset values of the pin path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      kc_meta_q <= 1'b1;
      kc_sync_q <= 1'b1;
      kd_meta_q <= 1'b1;
      kd_sync_q <= 1'b1;
      flt_cnt_q <= '0;
      flt_q     <= 1'b1;
      flt_dly_q <= 1'b1;
      to_cnt_q  <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      brk_q     <= 1'b0;
      ext_q     <= 1'b0;
      letter_q  <= '0;
      lv_q      <= 1'b0;
      pe_q      <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      kc_meta_q <= kc_meta_d;
      kc_sync_q <= kc_sync_d;
      kd_meta_q <= kd_meta_d;
      kd_sync_q <= kd_sync_d;
      flt_cnt_q <= flt_cnt_d;
      flt_q     <= flt_d;
      flt_dly_q <= flt_dly_d;
      to_cnt_q  <= to_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      brk_q     <= brk_d;
      ext_q     <= ext_d;
      letter_q  <= letter_d;
      lv_q      <= lv_d;
      pe_q      <= pe_d;
      fe_q      <= fe_d;
    end
  end

  assign letter       = letter_q;
  assign letter_valid = lv_q;
  assign parity_err   = pe_q;
  assign frame_err    = fe_q;

endmodule

// File: doc/ps2_letter_rx.md
# ps2_letter_rx

Receives PS/2 keyboard frames on the raw `kbdclk`/`kbddat` pins and turns scan-code set 2 make codes for A–Z into a 5-bit letter code (A=1 … Z=26). It sits directly upstream of the letter display decoder and the LED bank, and replaces the internal frame logic behind the keyboard wrapper. Frames are validated for start, parity and stop bits, and stalled frames are aborted by timeout. Break (`F0`) and extended (`E0`) sequences are filtered so that only key presses update the output.

## Interface
- `FILTER`, default 8: consecutive identical synchronized samples of `kbdclk` required before the filtered clock changes level.
- `TIMEOUT`, default 100_000: `clk` cycles without a filtered falling edge, mid-frame, before the frame is aborted (1 ms at 100 MHz).
- `clk`  in  1  system clock, 100 MHz. The only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `kbdclk`  in  1  raw PS/2 clock, asynchronous to `clk`.
- `kbddat`  in  1  raw PS/2 data, asynchronous to `clk`.
- `letter`  out  5  last accepted letter: 1–26, or 0 if none yet.
- `letter_valid`  out  1  one-cycle pulse when `letter` is written.
- `parity_err`  out  1  one-cycle pulse on a parity failure.
- `frame_err`  out  1  one-cycle pulse on a bad stop bit or a timeout.

## Operation
- **Input conditioning**
  - `kbdclk` and `kbddat` each pass through a 2-FF synchronizer.
  - The synchronized clock feeds a saturating filter counter. The filtered level (reset value 1) flips only after `FILTER` equal samples that differ from it.
  - A registered falling-edge detect on the filtered clock produces `fall`. Data is sampled from synchronized `kbddat` on the `fall` cycle.
- **Frame FSM**
  - `IDLE`: on `fall` with data 0 → `DATA`, bit count cleared. On `fall` with data 1 → stay in `IDLE`, no error pulse.
  - `DATA`: shift data in LSB first. After the 8th bit → `PARITY`.
  - `PARITY`: capture the bit → `STOP`.
  - `STOP`: on `fall`, evaluate the frame and go to `IDLE`.
    - Stop = 0 → `frame_err`.
    - Else if the XOR of the 8 data bits and the parity bit ≠ 1 (odd parity) → `parity_err`.
    - Else the byte is accepted.
  - In any state other than `IDLE`, a timeout counter counts cycles and clears on each `fall`. Reaching `TIMEOUT` → `frame_err`, `IDLE`, shift register discarded.
- **Byte layer**, flags `brk` and `ext`, both reset to 0
  - `E0` → set `ext`.
  - `F0` → set `brk`.
  - Any other byte: if `brk` or `ext` is set, clear both and make no output. Otherwise look the byte up in the letter table.
  - Letter table (set 2): A 1C, B 32, C 21, D 23, E 24, F 2B, G 34, H 33, I 43, J 3B, K 42, L 4B, M 3A, N 31, O 44, P 4D, Q 15, R 2D, S 1B, T 2C, U 3C, V 2A, W 1D, X 22, Y 35, Z 1A.
  - On a table hit, write `letter` and pulse `letter_valid`, including when the new value equals the old one (typematic repeat).
  - A non-letter byte leaves `letter` unchanged.
  - Errored frames do not touch `brk` or `ext`.
- **Reset**
  - Reset values: `letter`=0, all pulses 0, FSM in `IDLE`, flags and counters 0, filtered clock 1.
  - Reset asserted mid-frame abandons the partial frame. The next frame after release is received normally.

## Timing
- Pin to `fall`: 2 synchronizer cycles + `FILTER` cycles + 1 edge-register cycle after the raw falling edge.
- `letter`, `letter_valid`, `parity_err` and `frame_err` are registered and assert on the cycle after the stop-bit `fall`.
- Timeout `frame_err` asserts on the cycle after the counter reaches `TIMEOUT`.
- Pulses are exactly 1 cycle. At most one of the three pulses is asserted in any cycle.
- The next frame's start bit is accepted on the first `fall` after returning to `IDLE`, with no dead time.

## Test plan
- Reset, then frame `1C` with correct parity (0) and stop bit → `letter`=1, one `letter_valid` pulse.
- Sequence `1C`, `F0`, `1C` → exactly one `letter_valid`, `letter` stays 1. Then `1A` → `letter`=26.
- Sequence `E0`, `1C` → no pulse, `letter` unchanged. Then `32` → `letter`=2.
- Frame `24` with parity flipped → `parity_err` pulse, `letter` unchanged. Frame `24` with stop=0 → `frame_err` pulse only.
- Drive start + 4 data bits, then hold `kbdclk` high for `TIMEOUT`+10 cycles → `frame_err` pulse. A following good `21` frame → `letter`=3.
- Inject 3-cycle glitches on `kbdclk` with `FILTER`=8 → no bit sampled. Assert `rst_n` mid-frame → `letter`=0, and the next good `15` frame gives `letter`=17.
